// File: rtl/serial_tx_ctrl.sv
// Frame controller for a flex_pts_sr serial output register: wraps each accepted word
// in start/stop bits and drives the register's load/shift strobes with bit-period timing.
module serial_tx_ctrl #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter bit          SHIFT_MSB    = 1'b1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [DATA_BITS-1:0]   tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   pts_load,
    output logic                   pts_shift,
    output logic [DATA_BITS+1:0]   pts_data,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int unsigned FRAME_BITS = DATA_BITS + 2;
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_PARK = 2'd3;

    logic [1:0]            state_q,   state_d;
    logic [DATA_BITS-1:0]  data_q,    data_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] frame;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    data_d  = tx_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q < BIT_LAST) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        state_d = ST_PARK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_PARK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Start bit must sit on the end the downstream register shifts out first.
    always_comb begin
        frame = '1;
        if (SHIFT_MSB) begin
            frame[FRAME_BITS-1] = 1'b0;
            for (int unsigned i = 0; i < DATA_BITS; i++) begin
                frame[FRAME_BITS-2-i] = data_q[i];
            end
        end else begin
            frame[0] = 1'b0;
            for (int unsigned i = 0; i < DATA_BITS; i++) begin
                frame[i+1] = data_q[i];
            end
        end
    end

    assign tx_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign pts_load   = (state_q == ST_LOAD) || (state_q == ST_PARK);
    assign pts_shift  = (state_q == ST_SEND) && (clk_cnt_q == CLK_LAST) && (bit_cnt_q < BIT_LAST);
    assign pts_data   = (state_q == ST_LOAD) ? frame : '1;
    assign frame_done = (state_q == ST_PARK);

endmodule
